// File: rtl/ids_hdr_extract_if.sv
// Tuple bus between the header extractor and the rule matcher.
// One tuple per packet, transferred on tuple_valid && tuple_ready.
interface ids_hdr_extract_if;
  logic        tuple_valid;
  logic        tuple_ready;
  logic        tuple_ok;
  logic [31:0] src_ip;
  logic [31:0] dst_ip;
  logic [15:0] src_port;
  logic [15:0] dst_port;
  logic [7:0]  proto;

  modport master (
    output tuple_valid, tuple_ok, src_ip, dst_ip, src_port, dst_port, proto,
    input  tuple_ready
  );

  modport slave (
    input  tuple_valid, tuple_ok, src_ip, dst_ip, src_port, dst_port, proto,
    output tuple_ready
  );
endinterface

// File: rtl/ids_hdr_extract.sv
// Pops length-framed packets from the packet FIFO and extracts the IPv4 5-tuple
// from Ethernet/IPv4/TCP-UDP headers, one tuple per packet, plus packet counters.
module ids_hdr_extract #(
  parameter int          CNT_W    = 32,
  parameter logic [15:0] ETH_IPV4 = 16'h0800
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      fifo_rdata,
  input  logic             fifo_empty,
  output logic             fifo_ren,
  ids_hdr_extract_if.master tup,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  typedef enum logic [1:0] {DESC, BODY, EMIT} state_t;

  state_t      state, state_nxt;
  logic [15:0] len_q;
  logic [16:0] words_left;
  logic [2:0]  widx;
  logic [15:0] eth_type;
  logic [7:0]  ver_ihl;
  logic        hs;
  logic        ok;

  // Word index only needs to distinguish header words 0..4; everything past is "5".
  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v >= 3'd5) ? 3'd5 : v + 3'd1;
  endfunction

  assign hs = tup.tuple_valid && tup.tuple_ready;
  assign ok = (len_q >= 16'd38) && (eth_type == ETH_IPV4) && (ver_ihl == 8'h45) &&
              ((tup.proto == 8'd6) || (tup.proto == 8'd17));
  assign tup.tuple_ok = ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DESC;
    else     state <= state_nxt;
  end

  // Gating with rst keeps the pop request low while reset is held asynchronously.
  always_comb begin
    state_nxt       = state;
    fifo_ren        = 1'b0;
    tup.tuple_valid = 1'b0;
    case (state)
      DESC: begin
        fifo_ren = !rst && !fifo_empty;
        if (fifo_ren) state_nxt = (fifo_rdata[15:0] == 16'd0) ? EMIT : BODY;
      end
      BODY: begin
        fifo_ren = !rst && !fifo_empty;
        if (fifo_ren && (words_left == 17'd1)) state_nxt = EMIT;
      end
      EMIT: begin
        tup.tuple_valid = 1'b1;
        if (hs) state_nxt = DESC;
      end
      default: state_nxt = DESC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q        <= '0;
      words_left   <= '0;
      widx         <= '0;
      eth_type     <= '0;
      ver_ihl      <= '0;
      tup.proto    <= '0;
      tup.src_ip   <= '0;
      tup.dst_ip   <= '0;
      tup.src_port <= '0;
      tup.dst_port <= '0;
      pkt_cnt      <= '0;
      bad_cnt      <= '0;
    end else begin
      if (fifo_ren && (state == DESC)) begin
        len_q      <= fifo_rdata[15:0];
        words_left <= ({1'b0, fifo_rdata[15:0]} + 17'd7) >> 3;
        widx       <= '0;
      end
      if (fifo_ren && (state == BODY)) begin
        words_left <= words_left - 17'd1;
        widx       <= sat_inc(widx);
        case (widx)
          3'd1: begin
            eth_type <= fifo_rdata[31:16];
            ver_ihl  <= fifo_rdata[15:8];
          end
          3'd2: tup.proto <= fifo_rdata[7:0];
          3'd3: begin
            tup.src_ip        <= fifo_rdata[47:16];
            tup.dst_ip[31:16] <= fifo_rdata[15:0];
          end
          3'd4: begin
            tup.dst_ip[15:0] <= fifo_rdata[63:48];
            tup.src_port     <= fifo_rdata[47:32];
            tup.dst_port     <= fifo_rdata[31:16];
          end
          default: ;
        endcase
      end
      if (hs) begin
        pkt_cnt <= pkt_cnt + 1'b1;
        if (!ok) bad_cnt <= bad_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ids_hdr_extract.sv
// Directed bench for ids_hdr_extract: a queue-backed FIFO model feeds hand-built
// packets and each emitted tuple is compared with hand-computed values.
module tb_ids_hdr_extract;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] fifo_rdata = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_ren;
  logic [31:0] pkt_cnt, bad_cnt;

  ids_hdr_extract_if tup ();

  ids_hdr_extract #(.CNT_W(32), .ETH_IPV4(16'h0800)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_rdata (fifo_rdata),
    .fifo_empty (fifo_empty),
    .fifo_ren   (fifo_ren),
    .tup        (tup.master),
    .pkt_cnt    (pkt_cnt),
    .bad_cnt    (bad_cnt)
  );

  always #5 clk = ~clk;

  logic [63:0] q[$];
  logic        pop_pending   = 1'b0;
  logic        gap_mode      = 1'b0;
  logic        gap           = 1'b0;
  int          ren_count     = 0;
  int          empty_pop_err = 0;
  int          checks        = 0;
  int          failures      = 0;
  int          exp_pkt       = 0;
  int          exp_bad       = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // FIFO model: commit the previous cycle's pop, present the new head, then
  // sample fifo_ren once the inputs have settled for the coming edge.
  always @(negedge clk) begin
    if (rst) pop_pending = 1'b0;
    else if (pop_pending) begin
      if (q.size() > 0) void'(q.pop_front());
      ren_count++;
      pop_pending = 1'b0;
    end
    gap        = gap_mode ? ~gap : 1'b0;
    fifo_empty = (q.size() == 0) || gap;
    fifo_rdata = (q.size() > 0) ? q[0] : 64'h0;
    #1;
    if (fifo_ren && fifo_empty) empty_pop_err++;
    pop_pending = fifo_ren;
  end

  task automatic push_pkt(input int len, input logic [15:0] eth, input logic [7:0] vi,
                          input logic [7:0] pr, input logic [31:0] sip, input logic [31:0] dip,
                          input logic [15:0] sp, input logic [15:0] dp);
    logic [7:0]  b [0:71];
    logic [63:0] w;
    int          n;
    for (int i = 0; i < 72; i++) b[i] = 8'(i * 3 + 1);
    b[12] = eth[15:8];  b[13] = eth[7:0];  b[14] = vi;  b[23] = pr;
    b[26] = sip[31:24]; b[27] = sip[23:16]; b[28] = sip[15:8]; b[29] = sip[7:0];
    b[30] = dip[31:24]; b[31] = dip[23:16]; b[32] = dip[15:8]; b[33] = dip[7:0];
    b[34] = sp[15:8];   b[35] = sp[7:0];    b[36] = dp[15:8];  b[37] = dp[7:0];
    n = (len + 7) / 8;
    q.push_back({48'hA5A5_1234_5678, 16'(len)});
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 8; k++) w[63-8*k -: 8] = b[8*i+k];
      q.push_back(w);
    end
  endtask

  task automatic wait_valid(input string tag, input int bound);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk); #2;
      seen = tup.tuple_valid;
    end
    if (!seen) check_eq($sformatf("%s_timeout", tag), 64'(seen), 64'd1);
  endtask

  task automatic check_tuple(input string tag, input logic ok, input logic [31:0] sip,
                             input logic [31:0] dip, input logic [15:0] sp,
                             input logic [15:0] dp, input logic [7:0] pr);
    check_eq($sformatf("%s_ok", tag), 64'(tup.tuple_ok), 64'(ok));
    if (ok) begin
      check_eq($sformatf("%s_src_ip", tag), 64'(tup.src_ip), 64'(sip));
      check_eq($sformatf("%s_dst_ip", tag), 64'(tup.dst_ip), 64'(dip));
      check_eq($sformatf("%s_src_port", tag), 64'(tup.src_port), 64'(sp));
      check_eq($sformatf("%s_dst_port", tag), 64'(tup.dst_port), 64'(dp));
      check_eq($sformatf("%s_proto", tag), 64'(tup.proto), 64'(pr));
    end
  endtask

  // Called at negedge+2 with tuple_valid high; the accepting edge is the next posedge.
  task automatic handshake(input string tag, input logic ok);
    tup.tuple_ready = 1'b1;
    @(posedge clk); #1;
    tup.tuple_ready = 1'b0;
    exp_pkt++;
    if (!ok) exp_bad++;
    check_eq($sformatf("%s_valid_fall", tag), 64'(tup.tuple_valid), 64'd0);
    check_eq($sformatf("%s_pkt_cnt", tag), 64'(pkt_cnt), 64'(exp_pkt));
    check_eq($sformatf("%s_bad_cnt", tag), 64'(bad_cnt), 64'(exp_bad));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, stall_err;
    logic [31:0] held_ip;
    tup.tuple_ready = 1'b0;

    // Reset state
    #1 rst = 1'b1;
    #1;
    check_eq("rst_async_valid", 64'(tup.tuple_valid), 64'd0);
    check_eq("rst_async_pkt", 64'(pkt_cnt), 64'd0);
    repeat (3) @(negedge clk);
    #2;
    check_eq("rst_valid", 64'(tup.tuple_valid), 64'd0);
    check_eq("rst_ren", 64'(fifo_ren), 64'd0);
    check_eq("rst_ok", 64'(tup.tuple_ok), 64'd0);
    check_eq("rst_src_ip", 64'(tup.src_ip), 64'd0);
    check_eq("rst_bad", 64'(bad_cnt), 64'd0);
    rst = 1'b0;

    // TCP L=60: 10.0.0.1:1234 -> 10.0.0.2:80
    base = ren_count;
    push_pkt(60, 16'h0800, 8'h45, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80);
    wait_valid("tcp", 40);
    check_eq("tcp_pops", 64'(ren_count - base), 64'd9);
    check_tuple("tcp", 1'b1, 32'h0A000001, 32'h0A000002, 16'h04D2, 16'h0050, 8'd6);
    handshake("tcp", 1'b1);

    // ARP L=42, then a UDP packet
    base = ren_count;
    push_pkt(42, 16'h0806, 8'h45, 8'd6, 32'h01020304, 32'h05060708, 16'd1, 16'd2);
    wait_valid("arp", 40);
    check_eq("arp_pops", 64'(ren_count - base), 64'd7);
    check_tuple("arp", 1'b0, 0, 0, 0, 0, 0);
    handshake("arp", 1'b0);
    base = ren_count;
    push_pkt(42, 16'h0800, 8'h45, 8'd17, 32'hC0A8010A, 32'hC0A801FF, 16'd5353, 16'd53);
    wait_valid("udp", 40);
    check_eq("udp_pops", 64'(ren_count - base), 64'd7);
    check_tuple("udp", 1'b1, 32'hC0A8010A, 32'hC0A801FF, 16'h14E9, 16'h0035, 8'd17);
    handshake("udp", 1'b1);

    // Back-to-back packets with the consumer stalled
    push_pkt(60, 16'h0800, 8'h45, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80);
    push_pkt(54, 16'h0800, 8'h45, 8'd6, 32'hAC100005, 32'hAC100009, 16'd443, 16'd8080);
    wait_valid("b2b_a", 40);
    held_ip   = tup.src_ip;
    stall_err = 0;
    base      = ren_count;
    repeat (10) begin
      @(negedge clk); #2;
      if (!tup.tuple_valid || fifo_ren || tup.src_ip != held_ip) stall_err++;
    end
    check_eq("stall_viol", 64'(stall_err), 64'd0);
    check_eq("stall_pops", 64'(ren_count - base), 64'd0);
    check_tuple("b2b_a", 1'b1, 32'h0A000001, 32'h0A000002, 16'h04D2, 16'h0050, 8'd6);
    handshake("b2b_a", 1'b1);
    wait_valid("b2b_b", 40);
    check_tuple("b2b_b", 1'b1, 32'hAC100005, 32'hAC100009, 16'h01BB, 16'h1F90, 8'd6);
    handshake("b2b_b", 1'b1);

    // Gappy FIFO: same TCP packet
    gap_mode = 1'b1;
    base = ren_count;
    push_pkt(60, 16'h0800, 8'h45, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80);
    wait_valid("gap", 80);
    check_eq("gap_pops", 64'(ren_count - base), 64'd9);
    check_tuple("gap", 1'b1, 32'h0A000001, 32'h0A000002, 16'h04D2, 16'h0050, 8'd6);
    handshake("gap", 1'b1);
    gap_mode = 1'b0;

    // L=0 then L=20
    base = ren_count;
    push_pkt(0, 16'h0800, 8'h45, 8'd6, 32'h11111111, 32'h22222222, 16'd7, 16'd8);
    push_pkt(20, 16'h0800, 8'h45, 8'd6, 32'h11111111, 32'h22222222, 16'd7, 16'd8);
    wait_valid("len0", 40);
    check_eq("len0_pops", 64'(ren_count - base), 64'd1);
    check_tuple("len0", 1'b0, 0, 0, 0, 0, 0);
    handshake("len0", 1'b0);
    base = ren_count;
    wait_valid("len20", 40);
    check_eq("len20_pops", 64'(ren_count - base), 64'd4);
    check_tuple("len20", 1'b0, 0, 0, 0, 0, 0);
    handshake("len20", 1'b0);

    // Asynchronous reset in the middle of a UDP packet
    base = ren_count;
    push_pkt(50, 16'h0800, 8'h45, 8'd17, 32'h0A0A0A0A, 32'h0B0B0B0B, 16'd100, 16'd200);
    for (int i = 0; i < 50 && (ren_count - base) < 3; i++) begin
      @(negedge clk); #2;
    end
    check_eq("mid_in_body", 64'((ren_count - base) >= 3), 64'd1);
    #1 rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", 64'(tup.tuple_valid), 64'd0);
    check_eq("mid_rst_ren", 64'(fifo_ren), 64'd0);
    check_eq("mid_rst_pkt", 64'(pkt_cnt), 64'd0);
    check_eq("mid_rst_bad", 64'(bad_cnt), 64'd0);
    q.delete();
    exp_pkt = 0;
    exp_bad = 0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    push_pkt(46, 16'h0800, 8'h45, 8'd17, 32'hC0000201, 32'hC6336402, 16'd4000, 16'd5000);
    wait_valid("post_rst", 40);
    check_tuple("post_rst", 1'b1, 32'hC0000201, 32'hC6336402, 16'h0FA0, 16'h1388, 8'd17);
    handshake("post_rst", 1'b1);

    check_eq("no_pop_empty", 64'(empty_pop_err), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ids_hdr_extract.md
Name: ids_hdr_extract

Overview:
- Sits directly downstream of the 64-bit packet FIFO in the IDS datapath.
- Pops length-framed packet words from the FIFO and extracts the IPv4 5-tuple (src/dst IP, src/dst port, protocol) from Ethernet/IPv4/TCP-UDP headers.
- Presents one tuple per packet to the rule matcher over a valid/ready handshake, and keeps packet and bad-packet counters.

Parameters:
- CNT_W, 32, width of the pkt_cnt and bad_cnt counters (wrap on overflow).
- ETH_IPV4, 16'h0800, EtherType that identifies IPv4.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- fifo_rdata  in  64  head-of-queue word; valid whenever fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag.
- fifo_ren  out  1  pop request. Combinational.
- tuple_valid  out  1  tuple outputs are valid.
- tuple_ready  in  1  consumer accepts the tuple.
- tuple_ok  out  1  1 = packet parsed as IPv4 TCP/UDP; 0 = fields are don't-care.
- src_ip  out  32  IPv4 source address.
- dst_ip  out  32  IPv4 destination address.
- src_port  out  16  source port.
- dst_port  out  16  destination port.
- proto  out  8  IPv4 protocol field.
- pkt_cnt  out  CNT_W  packets completed.
- bad_cnt  out  CNT_W  packets completed with tuple_ok=0.

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-high. On rst, immediately: state=DESC, all outputs 0, counters 0.
- FIFO contract: fifo_rdata is the current head word. A cycle with fifo_ren=1 pops it; the next word is presented on the following cycle.
- fifo_ren = !fifo_empty && (state==DESC || state==BODY). The block never pops while the FIFO is empty.
- Framing: each packet is one descriptor word, then N=ceil(L/8) data words.
  - Descriptor: L = byte length in [15:0]; [63:16] are ignored.
  - Data words are big-endian: byte 0 is in [63:56] of data word 0.
- Field map (data word index : bits):
  - EtherType = w1[31:16]
  - version/IHL = w1[15:8]
  - proto = w2[7:0]
  - src_ip = w3[47:16]
  - dst_ip = {w3[15:0], w4[63:48]}
  - src_port = w4[47:32]
  - dst_port = w4[31:16]
- Fields are latched only on a pop at the matching word index. Words at index 5 and above are popped and discarded.
- FSM:
  - DESC: on pop, latch L; words_left = (L+7)>>3, computed 17-bit, giving 0..8192; clear the word index. If L==0, go to EMIT; else go to BODY.
  - BODY: on each pop, increment the word index and decrement words_left. The pop with words_left==1 goes to EMIT. No pop means hold state.
  - EMIT: tuple_valid=1, outputs stable. When tuple_valid && tuple_ready, go to DESC and tuple_valid falls the next cycle. No FIFO reads in EMIT; this is the backpressure stall.
- tuple_ok = 1 only if all of the following hold, else 0:
  - L >= 38
  - EtherType == ETH_IPV4
  - version/IHL == 8'h45
  - proto == 6 or proto == 17
- Counters: pkt_cnt increments by 1 on each EMIT handshake. bad_cnt also increments on that handshake when tuple_ok=0.
- Latency: tuple_valid rises the cycle after the last data word is popped. Minimum packet period is N+2 cycles.
- Short packets: when L < 38, the fields for missing words keep their prior values (don't-care) and tuple_ok=0. The declared word count is still consumed exactly, so the stream stays aligned.
- Reset mid-packet: the partial packet is abandoned and the next popped word is treated as a descriptor. Upstream must be flushed with the same reset.

Test Plan:
- TCP packet, L=60 (8 data words): 10.0.0.1:1234 -> 10.0.0.2:80, proto 6 -> src_ip=32'h0A000001, dst_ip=32'h0A000002, src_port=1234, dst_port=80, tuple_ok=1, pkt_cnt=1. fifo_ren is high for exactly 9 cycles.
- ARP frame, EtherType 0x0806, L=42 -> tuple_ok=0, bad_cnt=1, exactly 7 words popped. The following valid packet parses correctly.
- Two back-to-back packets with tuple_ready held low 10 cycles -> first tuple held stable, fifo_ren=0 throughout the stall. Second tuple emitted after the handshake; pkt_cnt=2.
- fifo_empty toggled every other cycle mid-packet -> no pop while empty; tuple identical to the gap-free run.
- L=0, then L=20 -> first emits after popping only the descriptor (tuple_ok=0). Second pops 1+3 words, tuple_ok=0, bad_cnt=2.
- rst asserted asynchronously during BODY of a UDP packet -> tuple_valid, fifo_ren and counters are 0 before the next clk edge. After release, a fresh descriptor parses correctly.
